// File: rtl/payment_change_ctrl.sv
// Payment side of the vending machine: accumulates coins against a latched price,
// dispenses when fully paid, then returns change one yuan per pulse.
module payment_change_ctrl #(
    parameter int unsigned MAX_PAID = 99,
    parameter int unsigned CHG_GAP  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] price,
    input  logic       coin1,
    input  logic       coin5,
    input  logic       coin10,
    input  logic       cancel,
    output logic [7:0] paid_bcd,
    output logic [7:0] change_bcd,
    output logic       dispense,
    output logic       change_pulse,
    output logic       coin_reject,
    output logic       busy,
    output logic [2:0] state
);

    localparam int unsigned GW = (CHG_GAP > 2) ? $clog2(CHG_GAP) : 1;
    localparam logic [7:0] MAX_P = 8'(MAX_PAID);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COLLECT  = 3'd1,
        DISPENSE = 3'd2,
        CHANGE   = 3'd3,
        WAIT_CLR = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    price_q, price_d;
    logic [6:0]    paid_q, paid_d;
    logic [6:0]    change_q, change_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          dispense_q, dispense_d;
    logic          pulse_q, pulse_d;
    logic          reject_q, reject_d;

    logic          coin_any;
    logic [3:0]    coin_val;
    logic          coin_multi;
    logic [7:0]    paid_sum;

    function automatic logic [7:0] bin2bcd(input logic [6:0] b);
        logic [14:0] s;
        s = {8'b0, b};
        for (int unsigned i = 0; i < 7; i++) begin
            if (s[10:7] >= 4'd5)  s[10:7]  = s[10:7] + 4'd3;
            if (s[14:11] >= 4'd5) s[14:11] = s[14:11] + 4'd3;
            s = s << 1;
        end
        return s[14:7];
    endfunction

    always_comb begin
        coin_any   = coin1 | coin5 | coin10;
        coin_val   = '0;
        coin_multi = 1'b0;
        case ({coin10, coin5, coin1})
            3'b000:  coin_val = 4'd0;
            3'b001:  coin_val = 4'd1;
            3'b010:  coin_val = 4'd5;
            3'b100:  coin_val = 4'd10;
            default: coin_multi = 1'b1;
        endcase
        paid_sum = {1'b0, paid_q} + {4'b0, coin_val};
    end

    always_comb begin
        state_d    = state_q;
        price_d    = price_q;
        paid_d     = paid_q;
        change_d   = change_q;
        gap_d      = gap_q;
        dispense_d = 1'b0;
        pulse_d    = 1'b0;
        reject_d   = 1'b0;
        case (state_q)
            IDLE: begin
                reject_d = coin_any;
                if (price != 4'd0) begin
                    price_d = price;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (cancel) begin
                    reject_d = coin_any;
                    change_d = paid_q;
                    paid_d   = '0;
                    gap_d    = '0;
                    state_d  = CHANGE;
                end else begin
                    if (coin_multi || (coin_any && paid_sum > MAX_P)) begin
                        reject_d = 1'b1;
                    end else if (coin_any) begin
                        paid_d = paid_sum[6:0];
                    end
                    // Decision uses the registered credit, so a completing coin dispenses one cycle later.
                    if (paid_q >= {3'b0, price_q}) begin
                        dispense_d = 1'b1;
                        state_d    = DISPENSE;
                    end
                end
            end
            DISPENSE: begin
                reject_d = coin_any;
                change_d = paid_q - {3'b0, price_q};
                paid_d   = '0;
                gap_d    = '0;
                state_d  = CHANGE;
            end
            CHANGE: begin
                reject_d = coin_any;
                if (change_q == '0) begin
                    state_d = WAIT_CLR;
                end else if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end else begin
                    pulse_d  = 1'b1;
                    change_d = change_q - 7'd1;
                    gap_d    = GW'(CHG_GAP - 1);
                end
            end
            WAIT_CLR: begin
                reject_d = coin_any;
                if (price == 4'd0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            price_q    <= '0;
            paid_q     <= '0;
            change_q   <= '0;
            gap_q      <= '0;
            dispense_q <= 1'b0;
            pulse_q    <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            price_q    <= price_d;
            paid_q     <= paid_d;
            change_q   <= change_d;
            gap_q      <= gap_d;
            dispense_q <= dispense_d;
            pulse_q    <= pulse_d;
            reject_q   <= reject_d;
        end
    end

    assign paid_bcd     = bin2bcd(paid_q);
    assign change_bcd   = bin2bcd(change_q);
    assign dispense     = dispense_q;
    assign change_pulse = pulse_q;
    assign coin_reject  = reject_q;
    assign busy         = (state_q != IDLE);
    assign state        = state_q;

endmodule
